alu_stim_gen: RTL and testbench

ALU_STIM_GEN -- requirements
Module: alu_stim_gen

---
 rtl/alu_stim_gen.sv | 124 ++++++++++++
 tb/tb_alu_stim_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_stim_gen.sv
// alu_stim_gen: steps an external ALU through 64 directed vectors and captures its results
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   step               raw pushbutton level, one vector per synchronised rising edge
//   auto               level, issue vectors back-to-back while high
//   F_in, ZF_in, OF_in result and flags from the ALU
//   A, B, ALU_OP       registered operands and opcode to the ALU
//   LED_SEL, LED       display select and display byte
//   busy, done         not-IDLE indicator, sticky all-vectors-captured flag
module alu_stim_gen #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        auto,
  input  logic [31:0] F_in,
  input  logic        ZF_in,
  input  logic        OF_in,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  ALU_OP,
  input  logic [2:0]  LED_SEL,
  output logic [7:0]  LED,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, CAPTURE} state_t;
  state_t      r_state, w_next;
  logic        r_sync1, r_sync2, r_prev, w_edge, w_busy;
  logic [2:0]  r_vld;
  logic [5:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [31:0] r_a, r_b, r_f, w_a, w_b;
  logic [2:0]  r_op;
  logic        r_zf, r_of, r_done;
  // r_vld fills with ones after reset so an edge is only reported once both the
  // synchronised level and its delayed copy hold real samples; a step held high
  // through reset release therefore never looks like a fresh press
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_sync1, r_sync2, r_prev, r_vld} <= '0;
    else begin
      r_sync1 <= step;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_vld   <= {r_vld[1:0], 1'b1};
    end
  assign w_edge = r_vld[2] & r_sync2 & ~r_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_edge || auto) ? ISSUE : IDLE;
      ISSUE:   w_next = SETTLE;
      SETTLE:  w_next = (r_cnt == 4'd0) ? CAPTURE : SETTLE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_busy = (r_state != IDLE);
  end
  always_comb begin
    w_a = 32'h0;
    w_b = 32'h0;
    case (r_idx[5:3])
      3'd1: begin w_a = 32'h0000_0003; w_b = 32'h0000_0607; end
      3'd2: begin w_a = 32'h8000_0000; w_b = 32'h8000_0000; end
      3'd3: begin w_a = 32'h7FFF_FFFF; w_b = 32'h7FFF_FFFF; end
      3'd4: begin w_a = 32'hFFFF_FFFF; w_b = 32'hFFFF_FFFF; end
      3'd5: begin w_a = 32'h8000_0000; w_b = 32'hFFFF_FFFF; end
      3'd6: begin w_a = 32'hFFFF_FFFF; w_b = 32'h8000_0000; end
      3'd7: begin w_a = 32'h1234_5678; w_b = 32'h3333_2222; end
      default: begin w_a = 32'h0; w_b = 32'h0; end
    endcase
  end
  // the settle counter is loaded with SETTLE_CYCLES-1 so SETTLE exits when it reads zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_f    <= '0;
      r_zf   <= 1'b0;
      r_of   <= 1'b0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      if (r_state == ISSUE) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_op  <= r_idx[2:0];
        r_cnt <= 4'(SETTLE_CYCLES - 1);
      end
      if (r_state == SETTLE && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (r_state == CAPTURE) begin
        r_f   <= F_in;
        r_zf  <= ZF_in;
        r_of  <= OF_in;
        r_idx <= r_idx + 6'd1;
        if (&r_idx) r_done <= 1'b1;
      end
    end
  always_comb begin
    LED = 8'h00;
    case (LED_SEL)
      3'd0: LED = r_f[7:0];
      3'd1: LED = r_f[15:8];
      3'd2: LED = r_f[23:16];
      3'd3: LED = r_f[31:24];
      3'd4: LED = {r_zf, 6'b0, r_of};
      3'd5: LED = {2'b0, r_idx};
      default: LED = 8'h00;
    endcase
  end
  assign A      = r_a;
  assign B      = r_b;
  assign ALU_OP = r_op;
  assign busy   = w_busy;
  assign done   = r_done;
endmodule

// File: tb/tb_alu_stim_gen.sv
// tb_alu_stim_gen: directed checks of alu_stim_gen against a small behavioural ALU
module tb_alu_stim_gen;
  logic        clk = 1'b0, rst_n, step, auto;
  logic [31:0] F_in, A, B;
  logic        ZF_in, OF_in, busy, done;
  logic [2:0]  ALU_OP, LED_SEL;
  logic [7:0]  LED;
  int          checks = 0, failures = 0;
  alu_stim_gen #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .auto(auto),
    .F_in(F_in), .ZF_in(ZF_in), .OF_in(OF_in),
    .A(A), .B(B), .ALU_OP(ALU_OP),
    .LED_SEL(LED_SEL), .LED(LED), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_comb begin
    F_in = 32'h0;
    OF_in = 1'b0;
    case (ALU_OP)
      3'd0: F_in = A & B;
      3'd1: F_in = A | B;
      3'd2: F_in = A ^ B;
      3'd3: F_in = ~(A | B);
      3'd4: begin F_in = A + B; OF_in = (A[31] == B[31]) && (F_in[31] != A[31]); end
      3'd5: begin F_in = A - B; OF_in = (A[31] != B[31]) && (F_in[31] != A[31]); end
      3'd6: F_in = {31'b0, $signed(A) < $signed(B)};
      default: F_in = B << A[4:0];
    endcase
    ZF_in = (F_in == 32'h0);
  end
  typedef struct {
    int          idx;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [2:0]  s0, s1, s2;
    logic [7:0]  l0, l1, l2;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic led_chk(input string name, input logic [2:0] sel, input logic [7:0] exp);
    LED_SEL = sel;
    #1;
    chk(name, {24'b0, LED}, {24'b0, exp});
  endtask
  task automatic do_vector(output logic [31:0] a, output logic [31:0] b, output logic [2:0] op);
    int n, bc;
    a = 'x; b = 'x; op = 'x;
    step = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    step = 1'b0;
    checks++;
    if (!busy) begin
      failures++;
      $display("FAIL issue_timeout actual=busy_low required=busy_high");
      return;
    end
    bc = 0;
    while (busy && bc < 20) begin
      a = A; b = B; op = ALU_OP;
      @(negedge clk);
      bc++;
    end
    chk("busy_len", bc, 4);
  endtask
  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [7:0]  v;
    int          cur, n;
    bit          seen;
    tbl[0] = '{0,  32'h0,          32'h0,          3'd0, 3'd4, 3'd0, 3'd6, 8'h80, 8'h00, 8'h00};
    tbl[1] = '{12, 32'h0000_0003,  32'h0000_0607,  3'd4, 3'd0, 3'd1, 3'd4, 8'h0A, 8'h06, 8'h00};
    tbl[2] = '{28, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  3'd4, 3'd3, 3'd0, 3'd4, 8'hFF, 8'hFE, 8'h01};
    tbl[3] = '{36, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'd4, 3'd0, 3'd3, 3'd4, 8'hFE, 8'hFF, 8'h00};
    tbl[4] = '{44, 32'h8000_0000,  32'hFFFF_FFFF,  3'd4, 3'd0, 3'd3, 3'd4, 8'hFF, 8'h7F, 8'h01};
    tbl[5] = '{58, 32'h1234_5678,  32'h3333_2222,  3'd2, 3'd0, 3'd1, 3'd7, 8'h5A, 8'h74, 8'h00};
    rst_n = 1'b0; step = 1'b1; auto = 1'b0; LED_SEL = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_op", {29'b0, ALU_OP}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    for (int s = 0; s < 6; s++) led_chk("rst_led", 3'(s), 8'h00);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (busy) seen = 1'b1; end
    chk("held_step_no_issue", {31'b0, seen}, 0);
    led_chk("held_step_idx", 3'd5, 8'h00);
    step = 1'b0;
    repeat (4) @(negedge clk);
    cur = 0;
    for (int i = 0; i < 6; i++) begin
      while (cur < tbl[i].idx) begin do_vector(a, b, op); cur++; end
      do_vector(a, b, op);
      cur++;
      chk("vec_A", a, tbl[i].a);
      chk("vec_B", b, tbl[i].b);
      chk("vec_op", {29'b0, op}, {29'b0, tbl[i].op});
      led_chk("vec_led_a", tbl[i].s0, tbl[i].l0);
      led_chk("vec_led_b", tbl[i].s1, tbl[i].l1);
      led_chk("vec_led_c", tbl[i].s2, tbl[i].l2);
      led_chk("vec_next_idx", 3'd5, 8'(cur));
    end
    led_chk("pulse_pre_idx", 3'd5, 8'(cur));
    v = LED;
    repeat (3) begin
      step = 1'b1; @(negedge clk);
      step = 1'b0; @(negedge clk);
    end
    repeat (15) @(negedge clk);
    led_chk("pulses_one_vector", 3'd5, v + 8'd1);
    chk("pulses_idle", {31'b0, busy}, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    repeat (5) do_vector(a, b, op);
    led_chk("pre_abort_flags", 3'd4, 8'h80);
    step = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    step = 1'b0;
    @(negedge clk);
    chk("abort_op_in_settle", {29'b0, ALU_OP}, 5);
    chk("abort_busy_in_settle", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_A", A, 0);
    chk("abort_B", B, 0);
    chk("abort_op", {29'b0, ALU_OP}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    led_chk("abort_flags", 3'd4, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    led_chk("abort_no_capture", 3'd4, 8'h00);
    led_chk("abort_idx", 3'd5, 8'h00);
    do_vector(a, b, op);
    chk("after_abort_op", {29'b0, op}, 0);
    led_chk("after_abort_idx", 3'd5, 8'h01);
    rst_n = 1'b0;
    auto = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (!(n >= 318 && n <= 322)) begin
      failures++;
      $display("FAIL auto_done_cycle actual=%0d required=320+/-2", n);
    end
    led_chk("auto_wrap_idx", 3'd5, 8'h00);
    auto = 1'b0;
    repeat (12) @(negedge clk);
    chk("done_sticky", {31'b0, done}, 1);
    chk("auto_stop_idle", {31'b0, busy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
